dsp19x2_result_checker: RTL and testbench

Self-checking receiver for the fractured 2×(10×9) DSP lanes used in the dsp19x2 test designs. It sits on the output side of an `RS_DSP_MULTACC` or `RS_DSP_MULT_REGOUT` instance. It takes the same operand stream that drives the DSP, computes a golden result for each lane, and delays it by the DSP pipeline latency. It then compares the golden result against `z1`/`z2` and reports mismatches, counts and a final pass/fail verdict.

---
 rtl/dsp19x2_result_checker.sv | 132 +++++++++++++
 tb/tb_dsp19x2_result_checker.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp19x2_result_checker.sv
// Golden-model checker for the fractured 2x(10x9) DSP lanes: rebuilds each lane's
// expected result, delays it by the DSP latency and compares it against z1/z2.
module dsp19x2_result_checker #(
  parameter int LATENCY     = 1,
  parameter int NUM_SAMPLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_acc,
  input  logic        load_acc,
  input  logic        valid_in,
  input  logic [9:0]  a1,
  input  logic [8:0]  b1,
  input  logic [9:0]  a2,
  input  logic [8:0]  b2,
  input  logic [18:0] z1,
  input  logic [18:0] z2,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        mismatch,
  output logic [15:0] err_count,
  output logic [15:0] chk_count,
  output logic [18:0] exp1,
  output logic [18:0] exp2,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  fill_cnt;
  logic        mode_q;
  logic [18:0] acc1, acc2;
  logic [18:0] p1, p2, gold1, gold2;
  logic        dl_vld [LATENCY];
  logic [18:0] dl_g1  [LATENCY];
  logic [18:0] dl_g2  [LATENCY];
  logic        cap_vld;
  logic [18:0] cap_g1, cap_g2, cap_z1, cap_z2;
  logic        start_ok, accept, cmp, cmp_bad, last_cmp;

  assign busy      = (state == FILL) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == 16'd0);
  assign state_dbg = state;

  assign start_ok = start && ((state == IDLE) || (state == DONE));
  assign accept   = valid_in && busy;
  assign cmp      = cap_vld && (state == CHECK);
  assign cmp_bad  = (cap_z1 != cap_g1) || (cap_z2 != cap_g2);
  assign last_cmp = cmp && (chk_count == 16'(NUM_SAMPLES - 1));

  // Products always fit in 19 bits; the accumulate sum wraps modulo 2^19.
  assign p1    = 19'(a1) * 19'(b1);
  assign p2    = 19'(a2) * 19'(b2);
  assign gold1 = (mode_q && load_acc) ? acc1 + p1 : p1;
  assign gold2 = (mode_q && load_acc) ? acc2 + p2 : p2;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (fill_cnt == 3'(LATENCY - 1)) state_nxt = CHECK;
      CHECK:   if (last_cmp) state_nxt = DONE;
      DONE:    if (start) state_nxt = FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      fill_cnt  <= 3'd0;
      mode_q    <= 1'b0;
      acc1      <= 19'd0;
      acc2      <= 19'd0;
      dl_vld    <= '{default: 1'b0};
      cap_vld   <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= 16'd0;
      chk_count <= 16'd0;
      exp1      <= 19'd0;
      exp2      <= 19'd0;
    end else begin
      state    <= state_nxt;
      fill_cnt <= (state == FILL) ? fill_cnt + 3'd1 : 3'd0;
      if (start_ok) begin
        mode_q    <= mode_acc;
        acc1      <= 19'd0;
        acc2      <= 19'd0;
        err_count <= 16'd0;
        chk_count <= 16'd0;
      end else if (accept) begin
        acc1 <= gold1;
        acc2 <= gold2;
      end
      // Valid bits are flushed whenever the checker is not running.
      dl_vld[0] <= accept;
      for (int i = 1; i < LATENCY; i++) dl_vld[i] <= busy && dl_vld[i-1];
      cap_vld  <= busy && dl_vld[LATENCY-1];
      mismatch <= cmp && cmp_bad;
      if (cmp) begin
        chk_count <= chk_count + 16'd1;
        if (cmp_bad && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        exp1 <= cap_g1;
        exp2 <= cap_g2;
      end
    end
  end

  // Golden data and the captured DSP outputs need no reset: only valid bits gate use.
  always_ff @(posedge clk) begin
    dl_g1[0] <= gold1;
    dl_g2[0] <= gold2;
    for (int i = 1; i < LATENCY; i++) begin
      dl_g1[i] <= dl_g1[i-1];
      dl_g2[i] <= dl_g2[i-1];
    end
    cap_g1 <= dl_g1[LATENCY-1];
    cap_g2 <= dl_g2[LATENCY-1];
    cap_z1 <= z1;
    cap_z2 <= z2;
  end

endmodule

// File: tb/tb_dsp19x2_result_checker.sv
// Randomized bench for dsp19x2_result_checker: three instances (different latency and
// run length) share operands and DSP outputs; a plain-arithmetic model plays the DSP.
module tb_dsp19x2_result_checker;

  localparam int SZ = 256;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  start_v = 3'b000;
  logic        mode_acc = 1'b0, load_acc = 1'b0, valid_in = 1'b0;
  logic [9:0]  a1 = '0, a2 = '0;
  logic [8:0]  b1 = '0, b2 = '0;
  logic [18:0] z1 = '0, z2 = '0;

  logic        o_busy [3];
  logic        o_done [3];
  logic        o_pass [3];
  logic        o_mismatch [3];
  logic [15:0] o_err [3];
  logic [15:0] o_chk [3];
  logic [18:0] o_exp1 [3];
  logic [18:0] o_exp2 [3];
  logic [1:0]  o_state [3];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    bit vld; int a1; int b1; int a2; int b2; bit load;
    bit o1en; bit o2en; int o1; int o2; int f1; int f2;
  } item_t;
  typedef struct { int due; int g1; int g2; bit bad; } exp_t;

  item_t items[$];
  exp_t  exp_q[$];
  bit    zset [SZ];
  int    zv1 [SZ];
  int    zv2 [SZ];

  dsp19x2_result_checker #(.LATENCY(1), .NUM_SAMPLES(1)) u_l1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .mode_acc(mode_acc), .load_acc(load_acc),
    .valid_in(valid_in), .a1(a1), .b1(b1), .a2(a2), .b2(b2), .z1(z1), .z2(z2),
    .busy(o_busy[0]), .done(o_done[0]), .pass(o_pass[0]), .mismatch(o_mismatch[0]),
    .err_count(o_err[0]), .chk_count(o_chk[0]), .exp1(o_exp1[0]), .exp2(o_exp2[0]),
    .state_dbg(o_state[0]));

  dsp19x2_result_checker #(.LATENCY(3), .NUM_SAMPLES(16)) u_l3_16 (
    .clk(clk), .reset(reset), .start(start_v[1]), .mode_acc(mode_acc), .load_acc(load_acc),
    .valid_in(valid_in), .a1(a1), .b1(b1), .a2(a2), .b2(b2), .z1(z1), .z2(z2),
    .busy(o_busy[1]), .done(o_done[1]), .pass(o_pass[1]), .mismatch(o_mismatch[1]),
    .err_count(o_err[1]), .chk_count(o_chk[1]), .exp1(o_exp1[1]), .exp2(o_exp2[1]),
    .state_dbg(o_state[1]));

  dsp19x2_result_checker #(.LATENCY(3), .NUM_SAMPLES(3)) u_l3_3 (
    .clk(clk), .reset(reset), .start(start_v[2]), .mode_acc(mode_acc), .load_acc(load_acc),
    .valid_in(valid_in), .a1(a1), .b1(b1), .a2(a2), .b2(b2), .z1(z1), .z2(z2),
    .busy(o_busy[2]), .done(o_done[2]), .pass(o_pass[2]), .mismatch(o_mismatch[2]),
    .err_count(o_err[2]), .chk_count(o_chk[2]), .exp1(o_exp1[2]), .exp2(o_exp2[2]),
    .state_dbg(o_state[2]));

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int sel);
    return (sel == 0) ? 1 : 3;
  endfunction

  function automatic int num_of(input int sel);
    return (sel == 0) ? 1 : ((sel == 1) ? 16 : 3);
  endfunction

  function automatic item_t mk(input bit vld, input int xa1, input int xb1, input int xa2,
                               input int xb2, input bit load);
    item_t it;
    it.vld = vld; it.a1 = xa1; it.b1 = xb1; it.a2 = xa2; it.b2 = xb2; it.load = load;
    it.o1en = 0; it.o2en = 0; it.o1 = 0; it.o2 = 0; it.f1 = 0; it.f2 = 0;
    return it;
  endfunction

  function automatic item_t rnd_item(input int vpct, input int fpct);
    item_t it;
    it = mk($urandom_range(99) < vpct, $urandom_range(1023), $urandom_range(511),
            $urandom_range(1023), $urandom_range(511), 1'($urandom_range(1)));
    if ($urandom_range(99) < fpct) begin
      if ($urandom_range(1) == 1) it.f1 = 1 << $urandom_range(18);
      else it.f2 = 1 << $urandom_range(18);
    end
    return it;
  endfunction

  // Driver + reference model: runs one start..done sequence on instance sel
  task automatic run(input int sel, input bit mode, input int abort_after, output bit aborted);
    int lat, n, e, idx, c_cnt, errs, acc1, acc2, g1, g2, zz1, zz2;
    bit mdone;
    item_t it;
    exp_t ex;
    lat = lat_of(sel); n = num_of(sel);
    aborted = 0; mdone = 0; idx = 0; c_cnt = 0; errs = 0; acc1 = 0; acc2 = 0;
    exp_q.delete();
    for (int i = 0; i < SZ; i++) zset[i] = 0;
    @(negedge clk);
    start_v = 3'b000; start_v[sel] = 1'b1; mode_acc = mode; valid_in = 1'b0;
    @(posedge clk); @(negedge clk);
    start_v = 3'b000;
    compared++;
    if (o_busy[sel] !== 1'b1 || o_done[sel] !== 1'b0 || o_chk[sel] !== 16'd0 || o_err[sel] !== 16'd0) begin
      mismatched++;
      $display("FAIL start_state[%0d]: busy=%0b done=%0b chk=%0d err=%0d want busy=1 done=0 chk=0 err=0",
               sel, o_busy[sel], o_done[sel], o_chk[sel], o_err[sel]);
    end
    for (int k = 0; k < 300 && !mdone && !aborted; k++) begin
      e = cyc + 1;
      if (idx < items.size()) begin it = items[idx]; idx++; end
      else it = mk(0, $urandom_range(1023), $urandom_range(511), $urandom_range(1023), $urandom_range(511), 0);
      valid_in = it.vld; load_acc = it.load;
      a1 = 10'(it.a1); b1 = 9'(it.b1); a2 = 10'(it.a2); b2 = 9'(it.b2);
      if (it.vld && !mdone) begin
        if (mode && it.load) begin
          acc1 = (acc1 + it.a1 * it.b1) % 524288;
          acc2 = (acc2 + it.a2 * it.b2) % 524288;
        end else begin
          acc1 = it.a1 * it.b1;
          acc2 = it.a2 * it.b2;
        end
        g1 = mode ? acc1 : it.a1 * it.b1;
        g2 = mode ? acc2 : it.a2 * it.b2;
        zz1 = it.o1en ? it.o1 : (g1 ^ it.f1);
        zz2 = it.o2en ? it.o2 : (g2 ^ it.f2);
        ex.due = e + lat + 1; ex.g1 = g1; ex.g2 = g2; ex.bad = (zz1 != g1) || (zz2 != g2);
        exp_q.push_back(ex);
        zset[(e + lat) % SZ] = 1; zv1[(e + lat) % SZ] = zz1; zv2[(e + lat) % SZ] = zz2;
      end
      if (zset[e % SZ]) begin
        z1 = 19'(zv1[e % SZ]); z2 = 19'(zv2[e % SZ]); zset[e % SZ] = 0;
      end else begin
        z1 = 19'($urandom); z2 = 19'($urandom);
      end
      @(posedge clk); @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        ex = exp_q.pop_front();
        c_cnt++;
        if (ex.bad) errs++;
        compared++;
        if (o_chk[sel] !== 16'(c_cnt) || o_err[sel] !== 16'(errs) || o_mismatch[sel] !== ex.bad) begin
          mismatched++;
          $display("FAIL compare_counts[%0d] cyc %0d: chk=%0d err=%0d mm=%0b want chk=%0d err=%0d mm=%0b",
                   sel, cyc, o_chk[sel], o_err[sel], o_mismatch[sel], c_cnt, errs, ex.bad);
        end
        compared++;
        if (o_exp1[sel] !== 19'(ex.g1) || o_exp2[sel] !== 19'(ex.g2)) begin
          mismatched++;
          $display("FAIL golden[%0d] cyc %0d: exp1=%0d exp2=%0d want %0d %0d",
                   sel, cyc, o_exp1[sel], o_exp2[sel], ex.g1, ex.g2);
        end
        if (c_cnt == n) begin
          mdone = 1;
          compared++;
          if (o_done[sel] !== 1'b1 || o_busy[sel] !== 1'b0 || o_pass[sel] !== (errs == 0)) begin
            mismatched++;
            $display("FAIL verdict[%0d]: done=%0b busy=%0b pass=%0b want done=1 busy=0 pass=%0b",
                     sel, o_done[sel], o_busy[sel], o_pass[sel], errs == 0);
          end
        end else begin
          compared++;
          if (o_done[sel] !== 1'b0 || o_busy[sel] !== 1'b1) begin
            mismatched++;
            $display("FAIL early_done[%0d]: done=%0b busy=%0b want done=0 busy=1", sel, o_done[sel], o_busy[sel]);
          end
        end
      end else begin
        compared++;
        if (o_mismatch[sel] !== 1'b0 || o_chk[sel] !== 16'(c_cnt) || o_busy[sel] !== 1'b1) begin
          mismatched++;
          $display("FAIL idle_cycle[%0d] cyc %0d: mm=%0b chk=%0d busy=%0b want mm=0 chk=%0d busy=1",
                   sel, cyc, o_mismatch[sel], o_chk[sel], o_busy[sel], c_cnt);
        end
      end
      if (abort_after > 0 && c_cnt == abort_after) aborted = 1;
    end
    valid_in = 1'b0;
    if (!mdone && !aborted) begin
      compared++; mismatched++;
      $display("FAIL timeout[%0d]: chk=%0d want %0d", sel, o_chk[sel], n);
    end
    if (mdone) begin
      valid_in = 1'b1; a1 = 10'($urandom); b1 = 9'($urandom); z1 = 19'($urandom); z2 = 19'($urandom);
      @(posedge clk); @(negedge clk);
      valid_in = 1'b0;
      compared++;
      if (o_chk[sel] !== 16'(n) || o_err[sel] !== 16'(errs) || o_done[sel] !== 1'b1 || o_mismatch[sel] !== 1'b0) begin
        mismatched++;
        $display("FAIL done_hold[%0d]: chk=%0d err=%0d done=%0b mm=%0b want chk=%0d err=%0d done=1 mm=0",
                 sel, o_chk[sel], o_err[sel], o_done[sel], o_mismatch[sel], n, errs);
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (o_busy[k] !== 1'b0 || o_done[k] !== 1'b0 || o_pass[k] !== 1'b0 || o_mismatch[k] !== 1'b0 ||
          o_err[k] !== 16'd0 || o_chk[k] !== 16'd0 || o_exp1[k] !== 19'd0 || o_exp2[k] !== 19'd0 ||
          o_state[k] !== 2'd0) begin
        mismatched++;
        $display("FAIL %s[%0d]: busy=%0b done=%0b pass=%0b mm=%0b err=%0d chk=%0d exp1=%0d exp2=%0d st=%0d want all 0",
                 tag, k, o_busy[k], o_done[k], o_pass[k], o_mismatch[k], o_err[k], o_chk[k],
                 o_exp1[k], o_exp2[k], o_state[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start_v = 3'b111; valid_in = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    start_v = 3'b000; valid_in = 1'b0; reset = 1'b1;
  endtask

  task automatic test_regout_basic();
    bit ab;
    items.delete();
    items.push_back(mk(1, 3, 5, 10, 7, 0));
    run(0, 0, 0, ab);
    compared++;
    if (o_exp1[0] !== 19'd15 || o_exp2[0] !== 19'd70 || o_pass[0] !== 1'b1) begin
      mismatched++;
      $display("FAIL regout_basic: exp1=%0d exp2=%0d pass=%0b want 15 70 1", o_exp1[0], o_exp2[0], o_pass[0]);
    end
  endtask

  task automatic test_max_operands();
    bit ab;
    items.delete();
    items.push_back(mk(1, 1023, 511, 1023, 511, 1));
    run(0, 0, 0, ab);
    compared++;
    if (o_exp1[0] !== 19'd522753 || o_exp2[0] !== 19'd522753 || o_err[0] !== 16'd0) begin
      mismatched++;
      $display("FAIL max_operands: exp1=%0d exp2=%0d err=%0d want 522753 522753 0", o_exp1[0], o_exp2[0], o_err[0]);
    end
  endtask

  task automatic test_acc_wrap();
    bit ab;
    item_t it;
    items.delete();
    items.push_back(mk(1, 1023, 511, 1023, 511, 1));
    items.push_back(mk(1, 1023, 511, 1023, 511, 1));
    items.push_back(mk(1, 0, 0, 0, 0, 1));
    run(2, 1, 0, ab);
    compared++;
    if (o_exp1[2] !== 19'd521218 || o_exp2[2] !== 19'd521218 || o_pass[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL acc_wrap: exp1=%0d exp2=%0d pass=%0b want 521218 521218 1", o_exp1[2], o_exp2[2], o_pass[2]);
    end
    items.delete();
    items.push_back(mk(1, 1023, 511, 1023, 511, 1));
    it = mk(1, 1023, 511, 1023, 511, 1);
    it.o1en = 1; it.o1 = 524287; it.o2en = 1; it.o2 = 524287;
    items.push_back(it);
    items.push_back(mk(1, 5, 6, 7, 8, 0));
    run(2, 1, 0, ab);
    compared++;
    if (o_err[2] !== 16'd1 || o_pass[2] !== 1'b0) begin
      mismatched++;
      $display("FAIL acc_saturating_dsp: err=%0d pass=%0b want 1 0", o_err[2], o_pass[2]);
    end
  endtask

  task automatic test_fault_injection();
    bit ab;
    item_t it;
    items.delete();
    for (int i = 0; i < 16; i++) begin
      it = mk(1, $urandom_range(1, 1023), $urandom_range(1, 511), $urandom_range(1, 1023),
              $urandom_range(1, 511), 0);
      if (i == 2) begin it.o2en = 1; it.o2 = 0; end
      items.push_back(it);
    end
    run(1, 0, 0, ab);
    compared++;
    if (o_err[1] !== 16'd1 || o_chk[1] !== 16'd16 || o_pass[1] !== 1'b0) begin
      mismatched++;
      $display("FAIL fault_injection: err=%0d chk=%0d pass=%0b want 1 16 0", o_err[1], o_chk[1], o_pass[1]);
    end
  endtask

  task automatic test_gaps_latency3();
    bit ab;
    bit pat [4] = '{1, 0, 1, 1};
    items.delete();
    for (int i = 0; i < 4; i++)
      items.push_back(mk(pat[i], $urandom_range(1023), $urandom_range(511), $urandom_range(1023),
                         $urandom_range(511), 0));
    run(2, 0, 0, ab);
    compared++;
    if (o_chk[2] !== 16'd3 || o_pass[2] !== 1'b1) begin
      mismatched++;
      $display("FAIL gaps_latency3: chk=%0d pass=%0b want 3 1", o_chk[2], o_pass[2]);
    end
  endtask

  task automatic test_back_to_back();
    bit ab;
    items.delete();
    for (int i = 0; i < 20; i++) items.push_back(rnd_item(100, 0));
    run(1, 1'($urandom_range(1)), 0, ab);
  endtask

  task automatic test_random();
    bit ab;
    for (int r = 0; r < 4; r++) begin
      items.delete();
      for (int i = 0; i < 60; i++) items.push_back(rnd_item(70, 12));
      run(1, 1'($urandom_range(1)), 0, ab);
    end
  endtask

  task automatic test_reset_midrun();
    bit ab;
    items.delete();
    for (int i = 0; i < 24; i++) items.push_back(rnd_item(100, 0));
    run(1, 0, 5, ab);
    compared++;
    if (ab !== 1'b1) begin
      mismatched++;
      $display("FAIL midrun_abort_point: aborted=%0b want 1", ab);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_cleared("midrun_reset");
    reset = 1'b1;
    items.delete();
    for (int i = 0; i < 16; i++) items.push_back(rnd_item(100, 0));
    run(1, 0, 0, ab);
    compared++;
    if (o_pass[1] !== 1'b1 || o_chk[1] !== 16'd16) begin
      mismatched++;
      $display("FAIL after_reset_run: pass=%0b chk=%0d want 1 16", o_pass[1], o_chk[1]);
    end
  endtask

  initial begin
    test_reset();
    test_regout_basic();
    test_max_operands();
    test_acc_wrap();
    test_fault_injection();
    test_gaps_latency3();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
